// File: rtl/star_extent_finder_if.sv
// Frame-buffer read port used by star_extent_finder.
// Ports (signals):
//   mem_addr     ADDR_W  pixel address y*IMG_W + x, held between strobes
//   mem_rd_en    1       one-cycle read strobe per probe
//   mem_rd_data  PIX_W   pixel value, valid RD_LAT cycles after the strobe
// Modports: master = the finder (issues reads), slave = the frame buffer.
interface star_extent_finder_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned PIX_W  = 3
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [PIX_W-1:0]  mem_rd_data;

  modport master (output mem_addr, output mem_rd_en, input mem_rd_data);
  modport slave  (input mem_addr, input mem_rd_en, output mem_rd_data);

endinterface

// File: rtl/star_extent_finder.sv
// Walks the frame buffer from a seed pixel to find a star's bounding box:
// left/right on the seed row, then top/bottom on the horizontal-midpoint column.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, x_in, y_in   seed request, sampled only while idle
//   busy, done          scan in progress / one-cycle completion pulse
//   seed_dark           seed was unlit or outside the image
//   left, right, mid_x  horizontal extent and its midpoint
//   top, bottom, mid_y  vertical extent on column mid_x and its midpoint
//   mem                 frame-buffer read port (master side)
module star_extent_finder #(
  parameter int unsigned IMG_W     = 160,
  parameter int unsigned IMG_H     = 120,
  parameter int unsigned XW        = 8,
  parameter int unsigned YW        = 7,
  parameter int unsigned PIX_W     = 3,
  parameter int unsigned THRESHOLD = 0,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned ADDR_W    = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] x_in,
  input  logic [YW-1:0] y_in,
  output logic          busy,
  output logic          done,
  output logic          seed_dark,
  output logic [XW-1:0] left,
  output logic [XW-1:0] right,
  output logic [XW-1:0] mid_x,
  output logic [YW-1:0] top,
  output logic [YW-1:0] bottom,
  output logic [YW-1:0] mid_y,
  star_extent_finder_if.master mem
);

  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_SEED, ST_LEFT, ST_RIGHT, ST_MIDX, ST_UP, ST_DOWN, ST_MIDY, ST_DONE
  } state_t;

  state_t            state, stateD;
  logic              waiting, waitingD;
  logic [CNT_W-1:0]  cnt, cntD;
  logic [XW-1:0]     cx, cxD, seedX, seedXD, nx, probeX;
  logic [YW-1:0]     cy, cyD, seedY, seedYD, ny, probeY;
  logic              issue, lit, sampleNow;
  logic [ADDR_W-1:0] addrD;
  logic [XW:0]       sumX;
  logic [YW:0]       sumY;
  logic [XW-1:0]     leftD, rightD, midXD;
  logic [YW-1:0]     topD, bottomD, midYD;
  logic              seedDarkD;

  assign lit       = mem.mem_rd_data > PIX_W'(THRESHOLD);
  assign sampleNow = waiting && (cnt == '0);
  assign addrD     = ADDR_W'(probeY) * ADDR_W'(IMG_W) + ADDR_W'(probeX);
  // Midpoint sums carry one extra bit so the halving cannot overflow.
  assign sumX      = {1'b0, left} + {1'b0, right};
  assign sumY      = {1'b0, top} + {1'b0, bottom};

  // Next-state and capture logic. A lit sample immediately issues the next
  // probe of the same scan, so back-to-back probes cost RD_LAT+1 cycles.
  always_comb begin
    stateD    = state;
    waitingD  = waiting;
    cntD      = cnt;
    cxD       = cx;
    cyD       = cy;
    seedXD    = seedX;
    seedYD    = seedY;
    nx        = cx;
    ny        = cy;
    probeX    = cx;
    probeY    = cy;
    issue     = 1'b0;
    leftD     = left;
    rightD    = right;
    midXD     = mid_x;
    topD      = top;
    bottomD   = bottom;
    midYD     = mid_y;
    seedDarkD = seed_dark;

    // Read-latency countdown; the probe ends when the counter reaches zero.
    if (waiting) begin
      if (cnt != '0) cntD = cnt - CNT_W'(1);
      else           waitingD = 1'b0;
    end

    case (state)
      ST_IDLE: begin
        if (start) begin
          seedXD    = x_in;
          seedYD    = y_in;
          cxD       = x_in;
          cyD       = y_in;
          seedDarkD = 1'b0;
          waitingD  = 1'b0;
          stateD    = ST_SEED;
        end
      end

      ST_SEED: begin
        if (!waiting) begin
          if ((32'(cx) >= IMG_W) || (32'(cy) >= IMG_H)) begin
            leftD = cx; rightD = cx; midXD = cx;
            topD  = cy; bottomD = cy; midYD = cy;
            seedDarkD = 1'b1;
            stateD    = ST_DONE;
          end else begin
            issue = 1'b1;
          end
        end else if (sampleNow) begin
          if (!lit) begin
            leftD = cx; rightD = cx; midXD = cx;
            topD  = cy; bottomD = cy; midYD = cy;
            seedDarkD = 1'b1;
            stateD    = ST_DONE;
          end else begin
            stateD = ST_LEFT;
          end
        end
      end

      ST_LEFT: begin
        if (!waiting || (sampleNow && lit)) begin
          nx = waiting ? cx - XW'(1) : cx;
          if (nx == '0) begin
            leftD  = '0;
            cxD    = seedX;
            stateD = ST_RIGHT;
          end else begin
            cxD    = nx;
            probeX = nx - XW'(1);
            issue  = 1'b1;
          end
        end else if (sampleNow) begin
          leftD  = cx;
          cxD    = seedX;
          stateD = ST_RIGHT;
        end
      end

      ST_RIGHT: begin
        if (!waiting || (sampleNow && lit)) begin
          nx = waiting ? cx + XW'(1) : cx;
          if (32'(nx) == IMG_W - 1) begin
            rightD = nx;
            stateD = ST_MIDX;
          end else begin
            cxD    = nx;
            probeX = nx + XW'(1);
            issue  = 1'b1;
          end
        end else if (sampleNow) begin
          rightD = cx;
          stateD = ST_MIDX;
        end
      end

      // The midpoint column pixel on the seed row is lit by contiguity.
      ST_MIDX: begin
        midXD  = XW'(sumX >> 1);
        cxD    = XW'(sumX >> 1);
        cyD    = seedY;
        stateD = ST_UP;
      end

      ST_UP: begin
        if (!waiting || (sampleNow && lit)) begin
          ny = waiting ? cy - YW'(1) : cy;
          if (ny == '0) begin
            topD   = '0;
            cyD    = seedY;
            stateD = ST_DOWN;
          end else begin
            cyD    = ny;
            probeY = ny - YW'(1);
            issue  = 1'b1;
          end
        end else if (sampleNow) begin
          topD   = cy;
          cyD    = seedY;
          stateD = ST_DOWN;
        end
      end

      ST_DOWN: begin
        if (!waiting || (sampleNow && lit)) begin
          ny = waiting ? cy + YW'(1) : cy;
          if (32'(ny) == IMG_H - 1) begin
            bottomD = ny;
            stateD  = ST_MIDY;
          end else begin
            cyD    = ny;
            probeY = ny + YW'(1);
            issue  = 1'b1;
          end
        end else if (sampleNow) begin
          bottomD = cy;
          stateD  = ST_MIDY;
        end
      end

      ST_MIDY: begin
        midYD  = YW'(sumY >> 1);
        stateD = ST_DONE;
      end

      ST_DONE: stateD = ST_IDLE;

      default: stateD = ST_IDLE;
    endcase

    if (issue) begin
      waitingD = 1'b1;
      cntD     = CNT_W'(RD_LAT);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      waiting       <= 1'b0;
      cnt           <= '0;
      cx            <= '0;
      cy            <= '0;
      seedX         <= '0;
      seedY         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      seed_dark     <= 1'b0;
      left          <= '0;
      right         <= '0;
      mid_x         <= '0;
      top           <= '0;
      bottom        <= '0;
      mid_y         <= '0;
      mem.mem_addr  <= '0;
      mem.mem_rd_en <= 1'b0;
    end else begin
      state         <= stateD;
      waiting       <= waitingD;
      cnt           <= cntD;
      cx            <= cxD;
      cy            <= cyD;
      seedX         <= seedXD;
      seedY         <= seedYD;
      busy          <= (stateD != ST_IDLE) && (stateD != ST_DONE);
      done          <= (stateD == ST_DONE);
      seed_dark     <= seedDarkD;
      left          <= leftD;
      right         <= rightD;
      mid_x         <= midXD;
      top           <= topD;
      bottom        <= bottomD;
      mid_y         <= midYD;
      mem.mem_rd_en <= issue;
      if (issue) mem.mem_addr <= addrD;
    end
  end

endmodule
